// File: rtl/pkg_display.sv
// Shared types and constants for the BCD 7-segment display block.
package pkg_display;

    // Double-dabble conversion FSM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 3;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Element [n] holds the pattern for digit n
    localparam logic [9:0][6:0] SEG_PATTERN = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Non-decimal nibbles cannot occur after a full conversion; show them as blank anyway
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_OFF;
        end
        return SEG_PATTERN[digit];
    endfunction

    // Double-dabble correction step for one BCD nibble
    function automatic logic [3:0] dabble_adj(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/module_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one shift per cycle).
module module_bin2bcd
    import pkg_display::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    state_t      state_q, state_d;
    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj;
    logic [2:0]  cnt_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start always restarts the conversion, whatever the current state
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = SHIFT;
        end else begin
            case (state_q)
                SHIFT:   if (cnt_q == 3'd7) state_d = COMMIT;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-nibble add-3 correction ahead of the shift
    always_comb begin
        bcd_adj = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
    end

    // Datapath: capture on start, then shift one binary MSB into the BCD register per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (state_q == SHIFT) begin
            bcd_q <= (bcd_adj << 1) | {11'd0, bin_q[7]};
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // A restart arriving in COMMIT discards the finished result
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == COMMIT) && !start;
        bcd  = bcd_q;
    end

endmodule

// File: rtl/module_bcd_display.sv
// Latches a/b/m on a load strobe, converts to BCD and scans it onto a 3-digit
// common-anode 7-segment display with leading-zero blanking.
module module_bcd_display
    import pkg_display::*;
#(
    parameter int unsigned CLK_DIV        = 27_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       load_m,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [7:0] m,
    output logic [2:0] anodo,
    output logic [6:0] catodo,
    output logic       busy
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0]  AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
    localparam logic [6:0]  CAT_OFF = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

    logic             start;
    logic [7:0]       load_val;
    logic             conv_done;
    logic [11:0]      conv_bcd;
    logic [11:0]      disp_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic [3:0]       cur_digit;
    logic             blank;
    logic [2:0]       an_al;
    logic [6:0]       seg_al;
    logic [2:0]       anodo_q;
    logic [6:0]       catodo_q;

    // Load arbitration: m wins over b wins over a
    always_comb begin
        start = load_a | load_b | load_m;
        if (load_m) begin
            load_val = m;
        end else if (load_b) begin
            load_val = {4'd0, b};
        end else begin
            load_val = {4'd0, a};
        end
    end

    module_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (load_val),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display registers only change on a completed conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q <= '0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Digit select, leading-zero blanking and segment decode (active-low domain)
    always_comb begin
        cur_digit = disp_q[3:0];
        blank     = 1'b0;
        an_al     = 3'b110;
        case (idx_q)
            2'd1: begin
                cur_digit = disp_q[7:4];
                blank     = (disp_q[11:4] == 8'd0);
                an_al     = 3'b101;
            end
            2'd2: begin
                cur_digit = disp_q[11:8];
                blank     = (disp_q[11:8] == 4'd0);
                an_al     = 3'b011;
            end
            default: ;
        endcase
        seg_al = blank ? SEG_OFF : seg_of(cur_digit);
    end

    // Registered outputs so anode and segments switch on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anodo_q  <= AN_OFF;
            catodo_q <= CAT_OFF;
        end else begin
            anodo_q  <= SEG_ACTIVE_LOW ? an_al : ~an_al;
            catodo_q <= SEG_ACTIVE_LOW ? seg_al : ~seg_al;
        end
    end

    assign anodo  = anodo_q;
    assign catodo = catodo_q;

endmodule
